// File: rtl/adc_vpp_bcd_meter.sv
`default_nettype none
// ============================================================================
//  Module      : adc_vpp_bcd_meter
//  Description : Measures the peak-to-peak amplitude of an ADC sample stream
//                over a fixed window of valid samples. Scales the result to
//                10 mV units and converts it to three packed BCD digits with
//                a sequential double-dabble engine. The result is held for a
//                7-segment display. Bit 12 of the output is the clip flag.
//  Revision    : 1.0 - initial release
// ============================================================================
module adc_vpp_bcd_meter #(
    parameter int ADC_W   = 12,
    parameter int WINDOW  = 1024,
    parameter int FS_CODE = 330
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sample_valid,
    input  logic [ADC_W-1:0] sample,
    output logic [12:0]      data_out,
    output logic             meas_done
);

    localparam int            CW     = (WINDOW > 2) ? $clog2(WINDOW) : 1;
    localparam int            PW     = ADC_W + 10;
    localparam logic [CW-1:0] C_LAST = CW'(WINDOW - 1);
    localparam logic [ADC_W-1:0] C_FULL = {ADC_W{1'b1}};

    typedef enum logic [1:0] {
        ST_ACQ  = 2'd0,
        ST_MUL  = 2'd1,
        ST_BCD  = 2'd2,
        ST_LOAD = 2'd3
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [CW-1:0]    r_cnt;
    logic [ADC_W-1:0] r_min;
    logic [ADC_W-1:0] r_max;
    logic             r_clip;
    logic [9:0]       r_val;
    logic [11:0]      r_bcd;
    logic [3:0]       r_iter;
    logic [12:0]      r_data_out;
    logic             r_meas_done;

    logic             w_acc;
    logic             w_last;
    logic [ADC_W-1:0] w_pp;
    logic [PW-1:0]    w_prod;
    logic [9:0]       w_val;
    logic [11:0]      w_adj;

    // Accept strobe: samples outside ACQ are simply dropped.
    assign w_acc  = (r_state == ST_ACQ) && sample_valid;
    assign w_last = w_acc && (r_cnt == C_LAST);

    // Scale peak-to-peak code to display LSBs; the shift discards the fraction.
    assign w_pp   = r_max - r_min;
    assign w_prod = PW'(w_pp) * PW'(FS_CODE);
    assign w_val  = 10'(w_prod >> ADC_W);

    // Double-dabble correction: each digit >= 5 gets +3 before the shift.
    always_comb begin
        w_adj = r_bcd;
        for (int d = 0; d < 3; d++) begin
            if (r_bcd[4*d +: 4] >= 4'd5) begin
                w_adj[4*d +: 4] = r_bcd[4*d +: 4] + 4'd3;
            end
        end
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_ACQ;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic: window complete -> multiply -> 10 BCD steps -> load.
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_ACQ:  if (w_last) w_next = ST_MUL;
            ST_MUL:  w_next = ST_BCD;
            ST_BCD:  if (r_iter == 4'd9) w_next = ST_LOAD;
            ST_LOAD: w_next = ST_ACQ;
            default: w_next = ST_ACQ;
        endcase
    end

    // Window acquisition: sample count, running min/max and clip detection.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt  <= '0;
            r_min  <= '0;
            r_max  <= '0;
            r_clip <= 1'b0;
        end else if (w_acc) begin
            r_cnt <= w_last ? '0 : r_cnt + 1'b1;
            if (r_cnt == '0) begin
                r_min <= sample;
                r_max <= sample;
            end else begin
                if (sample < r_min) r_min <= sample;
                if (sample > r_max) r_max <= sample;
            end
            if ((sample == '0) || (sample == C_FULL)) begin
                r_clip <= 1'b1;
            end
        end else if (r_state == ST_LOAD) begin
            r_min  <= '0;
            r_max  <= '0;
            r_clip <= 1'b0;
        end
    end

    // Conversion engine: latch scaled value, then shift it through the BCD digits.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_val  <= '0;
            r_bcd  <= '0;
            r_iter <= '0;
        end else if (r_state == ST_MUL) begin
            r_val  <= w_val;
            r_bcd  <= '0;
            r_iter <= '0;
        end else if (r_state == ST_BCD) begin
            r_bcd  <= {w_adj[10:0], r_val[9]};
            r_val  <= {r_val[8:0], 1'b0};
            r_iter <= r_iter + 4'd1;
        end
    end

    // Output hold register and completion pulse, updated together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_data_out  <= '0;
            r_meas_done <= 1'b0;
        end else begin
            r_meas_done <= (r_state == ST_LOAD);
            if (r_state == ST_LOAD) begin
                r_data_out <= {r_clip, r_bcd};
            end
        end
    end

    assign data_out  = r_data_out;
    assign meas_done = r_meas_done;

endmodule
`default_nettype wire
